// File: rtl/gpio_param_loader.sv
// gpio_param_loader: decodes a toggle-handshaked three-word host protocol
// (header, data low, data high/commit) arriving on a shared GP_IN word and
// writes complete 32-bit values into a bank of runtime parameters.
module gpio_param_loader #(
    parameter int                          PARAM_COUNT  = 16,
    parameter logic [3:0]                  SET_ID       = 4'd0,
    parameter logic [PARAM_COUNT*32-1:0]   RESET_VALUES = '0
) (
    input  logic                          CLK,
    input  logic                          RESETN,
    input  logic [31:0]                   GP_IN,
    output logic [31:0]                   GP_OUT,
    output logic [PARAM_COUNT*32-1:0]     PARAMS_DATA,
    output logic [PARAM_COUNT-1:0]        PARAM_UPDATE
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_LO      = 2'd2,
        ST_FOREIGN = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_HDR   = 2'd0,
        OP_DLO   = 2'd1,
        OP_DHI   = 2'd2,
        OP_ABORT = 2'd3
    } op_t;

    localparam logic [4:0] COUNT_LIMIT = 5'(PARAM_COUNT);

    // Capture pipeline: s1/s2 resynchronise GP_IN, s3 is the previous s2.
    logic [31:0] s1, s2, s3;
    logic        last_t;

    // Decoder state.
    state_t      state, state_nxt;
    logic        err, err_nxt;
    logic        ack_t;
    logic [3:0]  idx, idx_nxt;
    logic [15:0] lo, lo_nxt;
    logic        ack;
    logic        commit;

    // A new word is taken only once it has settled (two equal samples) and
    // its toggle bit differs from the last word taken.
    logic accept;
    op_t  op;
    logic own_set;
    logic index_ok;

    assign accept   = (s2[31] != last_t) && (s2 == s3);
    assign op       = op_t'(s2[30:29]);
    assign own_set  = (s2[27:24] == SET_ID);
    assign index_ok = ({1'b0, s2[3:0]} < COUNT_LIMIT);

    // Resynchronise the host word and remember the toggle of the last accepted word.
    always_ff @(posedge CLK) begin
        // NOTE: every clocked assignment is non-blocking so all flops sample
        // the pre-edge values of their sources, independent of statement order.
        if (!RESETN) begin
            s1     <= '0;
            s2     <= '0;
            s3     <= '0;
            last_t <= 1'b0;
        end else begin
            s1 <= GP_IN;
            s2 <= s1;
            s3 <= s2;
            if (accept) begin
                last_t <= s2[31];
            end
        end
    end

    // Protocol decode: next state, sticky error, latched index/low half, ack and commit.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_nxt = state;
        err_nxt   = err;
        idx_nxt   = idx;
        lo_nxt    = lo;
        ack       = 1'b0;
        commit    = 1'b0;

        if (accept) begin
            unique case (op)
                OP_HDR: begin
                    if (own_set) begin
                        ack = 1'b1;
                        if (index_ok) begin
                            idx_nxt   = s2[3:0];
                            state_nxt = ST_HDR;
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        state_nxt = ST_FOREIGN;
                    end
                end
                OP_DLO: begin
                    if (state != ST_FOREIGN) begin
                        ack = 1'b1;
                        if (state == ST_IDLE) begin
                            err_nxt = 1'b1;
                        end else begin
                            lo_nxt    = s2[15:0];
                            state_nxt = ST_LO;
                        end
                    end
                end
                OP_DHI: begin
                    if (state != ST_FOREIGN) begin
                        ack       = 1'b1;
                        state_nxt = ST_IDLE;
                        if (state == ST_LO) begin
                            commit = 1'b1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end
                OP_ABORT: begin
                    state_nxt = ST_IDLE;
                    if (state != ST_FOREIGN) begin
                        ack = 1'b1;
                        if (s2[0]) begin
                            err_nxt = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // Decoder state register; the ack bit echoes the toggle of each acknowledged word.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state <= ST_IDLE;
            err   <= 1'b0;
            ack_t <= 1'b0;
            idx   <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            err   <= err_nxt;
            idx   <= idx_nxt;
            lo    <= lo_nxt;
            if (ack) begin
                ack_t <= s2[31];
            end
        end
    end

    // Parameter bank: only a commit changes a value, and it pulses that parameter's update bit.
    always_ff @(posedge CLK) begin
        // NOTE: the bank is a set of flops with a defined power-up image that
        // downstream logic relies on, so it is reset, unlike a RAM would be.
        if (!RESETN) begin
            PARAMS_DATA  <= RESET_VALUES;
            PARAM_UPDATE <= '0;
        end else begin
            PARAM_UPDATE <= '0;
            for (int i = 0; i < PARAM_COUNT; i++) begin
                if (commit && (idx == 4'(i))) begin
                    PARAMS_DATA[i*32 +: 32] <= {s2[15:0], lo};
                    PARAM_UPDATE[i]         <= 1'b1;
                end
            end
        end
    end

    assign GP_OUT = {ack_t, state, err, SET_ID, 20'd0, idx};

endmodule

// File: tb/tb_gpio_param_loader.sv
// tb_gpio_param_loader: drives host command words with the toggle handshake
// and compares the loader against a protocol-level model of the host view.
`timescale 1ns/1ps
module tb_gpio_param_loader;

    localparam int         PC  = 8;
    localparam logic [3:0] SID = 4'd0;
    localparam logic [PC*32-1:0] RESET_IMG = {
        32'h8000_0007, 32'h6666_0006, 32'h5555_0005, 32'h4444_0004,
        32'h3333_0003, 32'h2222_0002, 32'h1234_5678, 32'h0000_0000
    };

    localparam logic [1:0] OP_HDR   = 2'd0;
    localparam logic [1:0] OP_DLO   = 2'd1;
    localparam logic [1:0] OP_DHI   = 2'd2;
    localparam logic [1:0] OP_ABORT = 2'd3;

    localparam logic [1:0] PH_IDLE    = 2'd0;
    localparam logic [1:0] PH_HDR     = 2'd1;
    localparam logic [1:0] PH_LO      = 2'd2;
    localparam logic [1:0] PH_FOREIGN = 2'd3;

    logic              clk = 1'b0;
    logic              resetn;
    logic [31:0]       gp_in;
    logic [31:0]       gp_out;
    logic [PC*32-1:0]  params_data;
    logic [PC-1:0]     param_update;

    int n_checks = 0;
    int n_fail   = 0;

    // Host-side bookkeeping.
    bit          host_t;
    logic [31:0] last_word;

    // Reference model of what the host should observe.
    logic [31:0] m_bank [PC];
    logic [1:0]  m_phase;
    bit          m_err;
    bit          m_ack;
    logic [3:0]  m_idx;
    logic [15:0] m_lo;

    gpio_param_loader #(
        .PARAM_COUNT (PC),
        .SET_ID      (SID),
        .RESET_VALUES(RESET_IMG)
    ) dut (
        .CLK         (clk),
        .RESETN      (resetn),
        .GP_IN       (gp_in),
        .GP_OUT      (gp_out),
        .PARAMS_DATA (params_data),
        .PARAM_UPDATE(param_update)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_gp();
        return {m_ack, m_phase, m_err, SID, 20'd0, m_idx};
    endfunction

    function automatic logic [PC*32-1:0] model_flat();
        logic [PC*32-1:0] f;
        for (int i = 0; i < PC; i++) f[i*32 +: 32] = m_bank[i];
        return f;
    endfunction

    task automatic model_reset();
        logic [PC*32-1:0] img;
        img = RESET_IMG;
        for (int i = 0; i < PC; i++) m_bank[i] = img[i*32 +: 32];
        m_phase = PH_IDLE;
        m_err   = 1'b0;
        m_ack   = 1'b0;
        m_idx   = '0;
        m_lo    = '0;
        host_t  = 1'b0;
    endtask

    task automatic model_apply(input logic [31:0] word, output logic [PC-1:0] upd);
        bit acked;
        acked = 1'b0;
        upd   = '0;
        case (word[30:29])
            OP_HDR: begin
                if (word[27:24] == SID) begin
                    acked = 1'b1;
                    if (int'(word[3:0]) < PC) begin
                        m_idx   = word[3:0];
                        m_phase = PH_HDR;
                    end else begin
                        m_err   = 1'b1;
                        m_phase = PH_IDLE;
                    end
                end else begin
                    m_phase = PH_FOREIGN;
                end
            end
            OP_DLO: begin
                if (m_phase == PH_IDLE) begin
                    acked = 1'b1;
                    m_err = 1'b1;
                end else if (m_phase != PH_FOREIGN) begin
                    acked   = 1'b1;
                    m_lo    = word[15:0];
                    m_phase = PH_LO;
                end
            end
            OP_DHI: begin
                if (m_phase == PH_LO) begin
                    acked = 1'b1;
                    m_bank[int'(m_idx)] = {word[15:0], m_lo};
                    upd     = PC'(1) << m_idx;
                    m_phase = PH_IDLE;
                end else if (m_phase != PH_FOREIGN) begin
                    acked   = 1'b1;
                    m_err   = 1'b1;
                    m_phase = PH_IDLE;
                end
            end
            default: begin
                if (m_phase != PH_FOREIGN) begin
                    acked = 1'b1;
                    if (word[0]) m_err = 1'b0;
                end
                m_phase = PH_IDLE;
            end
        endcase
        if (acked) m_ack = word[31];
    endtask

    // ---------------- host driver ----------------
    task automatic send_word(input logic [1:0] op, input logic [3:0] set,
                             input logic [15:0] payload, input string name,
                             output logic [PC-1:0] upd_seen);
        logic [31:0]    word, prev_gp, exp_gp;
        logic [PC-1:0]  exp_upd;
        host_t  = ~host_t;
        word    = {host_t, op, 1'b0, set, 8'h00, payload};
        prev_gp = model_gp();
        model_apply(word, exp_upd);
        exp_gp  = model_gp();
        @(negedge clk);
        gp_in     = word;
        last_word = word;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (gp_out !== prev_gp) begin
                n_fail++;
                $display("FAIL %s early_gp_out edge %0d: got %h want %h", name, k, gp_out, prev_gp);
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (gp_out !== exp_gp) begin
            n_fail++;
            $display("FAIL %s gp_out: got %h want %h", name, gp_out, exp_gp);
        end
        n_checks++;
        if (param_update !== exp_upd) begin
            n_fail++;
            $display("FAIL %s param_update: got %h want %h", name, param_update, exp_upd);
        end
        n_checks++;
        if (params_data !== model_flat()) begin
            n_fail++;
            $display("FAIL %s params_data: got %h want %h", name, params_data, model_flat());
        end
        upd_seen = param_update;
        @(posedge clk); #1;
        n_checks++;
        if (param_update !== '0) begin
            n_fail++;
            $display("FAIL %s update_pulse_width: got %h want 0", name, param_update);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] p1;
        resetn = 1'b0;
        gp_in  = '0;
        last_word = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        @(posedge clk); #1;
        n_checks++;
        if (gp_out !== (32'(SID) << 24)) begin
            n_fail++;
            $display("FAIL reset gp_out: got %h want %h", gp_out, 32'(SID) << 24);
        end
        n_checks++;
        if (params_data !== RESET_IMG) begin
            n_fail++;
            $display("FAIL reset params_data: got %h want %h", params_data, RESET_IMG);
        end
        p1 = params_data[32 +: 32];
        n_checks++;
        if (p1 !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL reset param1: got %h want 12345678", p1);
        end
        n_checks++;
        if (param_update !== '0) begin
            n_fail++;
            $display("FAIL reset param_update: got %h want 0", param_update);
        end
    endtask

    task automatic test_write_sequence();
        logic [PC-1:0] upd;
        logic [31:0]   p3;
        send_word(OP_HDR, SID, 16'd3, "wr_hdr", upd);
        send_word(OP_DLO, SID, 16'hBEEF, "wr_dlo", upd);
        send_word(OP_DHI, SID, 16'hDEAD, "wr_dhi", upd);
        n_checks++;
        if (upd !== 8'h08) begin
            n_fail++;
            $display("FAIL wr_update_bit: got %h want 08", upd);
        end
        p3 = params_data[3*32 +: 32];
        n_checks++;
        if (p3 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL wr_param3: got %h want deadbeef", p3);
        end
        n_checks++;
        if (gp_out[30:28] !== 3'b000) begin
            n_fail++;
            $display("FAIL wr_final_state_err: got %b want 000", gp_out[30:28]);
        end
    endtask

    task automatic test_error_clear();
        logic [PC-1:0]    upd;
        logic [PC*32-1:0] img;
        img = RESET_IMG;
        send_word(OP_HDR, SID, 16'd2, "err_hdr", upd);
        send_word(OP_DHI, SID, 16'h5A5A, "err_dhi", upd);
        n_checks++;
        if (gp_out[30:28] !== 3'b001) begin
            n_fail++;
            $display("FAIL err_set: got state/err %b want 001", gp_out[30:28]);
        end
        n_checks++;
        if (params_data[2*32 +: 32] !== img[2*32 +: 32]) begin
            n_fail++;
            $display("FAIL err_param2: got %h want %h", params_data[2*32 +: 32], img[2*32 +: 32]);
        end
        send_word(OP_ABORT, SID, 16'd1, "err_abort_clr", upd);
        n_checks++;
        if (gp_out[28] !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cleared: got %b want 0", gp_out[28]);
        end
    endtask

    task automatic test_foreign();
        logic [PC-1:0] upd;
        logic          ack_before;
        ack_before = gp_out[31];
        send_word(OP_HDR, 4'd5, 16'd1, "fgn_hdr", upd);
        send_word(OP_DLO, 4'd5, 16'h1111, "fgn_dlo", upd);
        send_word(OP_DHI, 4'd5, 16'h2222, "fgn_dhi", upd);
        n_checks++;
        if (gp_out[31] !== ack_before || gp_out[30:29] !== 2'd3) begin
            n_fail++;
            $display("FAIL fgn_silent: got ack %b state %0d want ack %b state 3",
                     gp_out[31], gp_out[30:29], ack_before);
        end
        n_checks++;
        if (upd !== '0) begin
            n_fail++;
            $display("FAIL fgn_no_update: got %h want 0", upd);
        end
        send_word(OP_HDR, SID, 16'd1, "fgn_own_hdr", upd);
        n_checks++;
        if (gp_out[31] !== host_t || gp_out[30:29] !== 2'd1) begin
            n_fail++;
            $display("FAIL fgn_resume: got ack %b state %0d want ack %b state 1",
                     gp_out[31], gp_out[30:29], host_t);
        end
        send_word(OP_ABORT, SID, 16'd0, "fgn_abort", upd);
    endtask

    task automatic test_out_of_range();
        logic [PC-1:0] upd;
        send_word(OP_HDR, SID, 16'd12, "oor_hdr12", upd);
        n_checks++;
        if (gp_out[30:28] !== 3'b001 || gp_out[31] !== host_t) begin
            n_fail++;
            $display("FAIL oor_err: got %h want state 0 err 1 ack %b", gp_out, host_t);
        end
        send_word(OP_DLO, SID, 16'h7777, "oor_dlo", upd);
        n_checks++;
        if (gp_out[28] !== 1'b1 || upd !== '0) begin
            n_fail++;
            $display("FAIL oor_sticky: got err %b upd %h want err 1 upd 0", gp_out[28], upd);
        end
        send_word(OP_ABORT, SID, 16'd1, "oor_clr", upd);
        send_word(OP_HDR, SID, 16'd7, "oor_hdr7_last_valid", upd);
        send_word(OP_HDR, SID, 16'd8, "oor_hdr8_first_bad", upd);
        send_word(OP_ABORT, SID, 16'd1, "oor_clr2", upd);
    endtask

    task automatic test_glitch();
        logic [31:0] held, exp_gp;
        held   = last_word;
        exp_gp = model_gp();
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (k < 5 && (k % 2 == 0))
                gp_in = {~held[31], $urandom_range(0, 32'h7FFF_FFFF)} ;
            else
                gp_in = held;
            @(posedge clk); #1;
            n_checks++;
            if (gp_out !== exp_gp || param_update !== '0) begin
                n_fail++;
                $display("FAIL glitch cycle %0d: got gp_out %h upd %h want %h upd 0",
                         k, gp_out, param_update, exp_gp);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        logic [PC-1:0] upd;
        if (host_t) send_word(OP_ABORT, SID, 16'd0, "rst_align", upd);
        send_word(OP_HDR, SID, 16'd5, "rst_hdr", upd);
        send_word(OP_DLO, SID, 16'h4321, "rst_dlo", upd);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (gp_out !== (32'(SID) << 24)) begin
                n_fail++;
                $display("FAIL rst_idle cycle %0d: got %h want %h", k, gp_out, 32'(SID) << 24);
            end
        end
        send_word(OP_DHI, SID, 16'h8765, "rst_dhi", upd);
        n_checks++;
        if (gp_out[30:28] !== 3'b001 || upd !== '0) begin
            n_fail++;
            $display("FAIL rst_dhi_err: got state/err %b upd %h want 001 upd 0", gp_out[30:28], upd);
        end
        n_checks++;
        if (params_data !== RESET_IMG) begin
            n_fail++;
            $display("FAIL rst_bank: got %h want %h", params_data, RESET_IMG);
        end
    endtask

    task automatic test_random();
        logic [PC-1:0] upd;
        logic [1:0]    op;
        logic [3:0]    set;
        logic [15:0]   payload;
        for (int n = 0; n < 60; n++) begin
            op      = 2'($urandom_range(0, 3));
            set     = ($urandom_range(0, 3) == 0) ? 4'd5 : SID;
            payload = 16'($urandom_range(0, 16'hFFFF));
            send_word(op, set, payload, $sformatf("rand%0d", n), upd);
        end
    endtask

    initial begin
        resetn = 1'b0;
        gp_in  = '0;
        model_reset();
        test_reset();
        test_write_sequence();
        test_error_clear();
        test_foreign();
        test_out_of_range();
        test_glitch();
        test_reset_mid_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_param_loader.md
Name: gpio_param_loader

Overview:
- Sequences host (PS GPIO) writes into a bank of PARAM_COUNT 32-bit runtime parameters.
- Sits beside the parameter readback mux on the same 32-bit GP_IN/GP_OUT pair.
- Decodes a toggle-handshaked three-word protocol: header, data low, data high/commit.
- Several instances (distinct SET_ID) share one GP_IN; only the addressed set acts.

Parameters:
- PARAM_COUNT, 16, number of parameters (1..16).
- SET_ID, 0, 4-bit set number this instance answers to.
- RESET_VALUES, 0, PARAM_COUNT*32-bit flat reset image of the bank.

Ports:
- CLK  input  1  system clock.
- RESETN  input  1  synchronous reset, active-low.
- GP_IN  input  32  host command word (asynchronous to CLK).
- GP_OUT  output  32  status/ack word to host.
- PARAMS_DATA  output  PARAM_COUNT*32  parameter bank; parameter i at [i*32 +: 32].
- PARAM_UPDATE  output  PARAM_COUNT  one-cycle pulse on bit i when parameter i commits.

Behaviour:
- Command word fields:
  - [31] T, toggle strobe.
  - [30:29] OP: 00 HDR, 01 DLO, 10 DHI, 11 ABORT.
  - [27:24] SET.
  - [3:0] INDEX (HDR only).
  - [15:0] half-word (DLO/DHI).
  - [0] CLR_ERR (ABORT only).
- Input capture:
  - GP_IN passes through two sync flops (s1, s2); s3 holds the previous s2.
  - A word is accepted when s2[31] != last_T and s2 == s3.
  - On acceptance, last_T <= s2[31].
  - The action registers on the 4th CLK edge after a GP_IN change.
  - A word changing during capture is not accepted until it has been stable for one cycle.
- States: IDLE, HDR, LO, FOREIGN.
  - Any state, HDR with SET==SET_ID and INDEX<PARAM_COUNT: latch idx, -> HDR, ack.
  - Any state, HDR with SET==SET_ID and INDEX>=PARAM_COUNT: set ERR, -> IDLE, ack.
  - Any state, HDR with SET!=SET_ID: -> FOREIGN, no ack.
  - FOREIGN: DLO/DHI ignored without ack; ABORT -> IDLE without ack.
  - HDR + DLO: latch lo[15:0], -> LO, ack.
  - HDR + DHI: set ERR, -> IDLE, ack.
  - LO + DLO: overwrite lo, stay LO, ack.
  - LO + DHI: commit, -> IDLE, ack.
  - IDLE + DLO or DHI: set ERR, stay IDLE, ack.
  - ABORT while not FOREIGN: -> IDLE, ack; if CLR_ERR, clear ERR.
- Commit:
  - PARAMS_DATA[idx] <= {DHI[15:0], lo}.
  - PARAM_UPDATE[idx] = 1 for exactly the commit cycle.
  - Other parameters are unchanged.
- Ack: ACK_T <= accepted T on every acked word.
- GP_OUT:
  - [31] ACK_T.
  - [30:29] state (IDLE=0, HDR=1, LO=2, FOREIGN=3).
  - [28] ERR (sticky).
  - [27:24] SET_ID.
  - [3:0] latched idx.
  - All other bits 0.
- Reset (RESETN=0 at a CLK edge):
  - PARAMS_DATA = RESET_VALUES.
  - PARAM_UPDATE = 0.
  - State IDLE, ERR=0, ACK_T=0, idx=0, lo=0, sync flops 0.
  - last_T = 0, so a T=1 word is the first accepted after reset.
  - Reset mid-sequence discards the partial write; no commit occurs.
- No partial writes: the bank changes only on commit.
- Ack toggles only for own-set words.
- Host waits for GP_OUT[31]==T before issuing the next word.

Test Plan:
1. Reset with RESET_VALUES[1]=0x12345678 -> PARAMS_DATA[1]=0x12345678, GP_OUT=SET_ID<<24, PARAM_UPDATE=0.
2. Write sequence:
   - Stimulus, SET_ID=0: HDR idx 3 (T=1), DLO 0xBEEF (T=0), DHI 0xDEAD (T=1), each issued after ack.
   - Required: PARAMS_DATA[3]=0xDEADBEEF; PARAM_UPDATE=0x0008 for one cycle.
   - Required: each ack 4 edges after its GP_IN change; final state IDLE, ERR=0.
3. Error and clear:
   - DHI directly after HDR idx 2 -> ERR=1, state IDLE, PARAMS_DATA[2] unchanged, ack given.
   - Then ABORT with CLR_ERR=1 -> ERR=0.
4. Foreign set on SET_ID=0 instance:
   - HDR SET=5 idx 1, then DLO, then DHI -> no ack toggle, state FOREIGN, no PARAM_UPDATE, bank unchanged.
   - Then HDR SET=0 -> state HDR, ack resumes.
5. Out-of-range index, PARAM_COUNT=8:
   - HDR idx 12 -> ERR=1, state IDLE, ack.
   - Following DLO -> ack, ERR stays 1, no commit.
6. Glitch and reset:
   - GP_IN alternates each cycle for 5 cycles -> nothing accepted.
   - HDR + DLO, then RESETN low 1 cycle, then DHI -> ERR=1 (IDLE+DHI), no commit, bank equals RESET_VALUES.
